mist_sd_track_cache: RTL and testbench
======================================

Name: mist_sd_track_cache

Overview:
- Multi-drive successor to the single-drive Apple ][ track buffer.
- Holds one full track per drive in dual-port RAM and serves the disk controller byte-wise.
- Shares one MiST SD block interface among all drives with round-robin arbitration.
- Writes dirty tracks back before a track change, on unmount, or when the drive goes idle.

Parameters:
- DRIVES, 2, number of independent drives/images (1..4)
- SECTORS, 13, 512-byte sectors per track (Apple nibble track 1A00h = 13)
- TRACK_W, 6, width of track number; all-ones = "no track loaded"

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sd_lba  out  32  sector address of current transfer
- sd_rd  out  DRIVES  per-image read request; at most one bit set
- sd_wr  out  DRIVES  per-image write request; at most one bit set
- sd_ack  in  1  IO controller busy with current sector
- sd_buff_addr  in  9  byte index within sector
- sd_buff_dout  in  8  sector data from IO controller
- sd_buff_din  out  8  sector data to IO controller, 1-cycle read latency
- sd_buff_wr  in  1  write strobe for sd_buff_dout, qualified by sd_ack
- change  in  DRIVES  per-drive image change strobe
- mount  in  DRIVES  per-drive image present, sampled on change rising edge
- track  in  DRIVES*TRACK_W  requested track per drive, drive d at [d*TRACK_W +: TRACK_W]
- active  in  DRIVES  drive motor on; write-back deferred while 1
- ready  out  DRIVES  image mounted and usable
- busy  out  DRIVES  track buffer of drive d being transferred
- ram_addr  in  DRIVES*A  per-drive byte address, A = clog2(SECTORS*512)
- ram_di  in  DRIVES*8  per-drive write data
- ram_we  in  DRIVES  per-drive write enable
- ram_do  out  DRIVES*8  per-drive read data, 1-cycle latency

Behaviour:
- Reset (reset_n low, asynchronous): ready = 0, busy = 0, sd_rd = 0, sd_wr = 0, sd_lba = 0, all cur_track = all-ones, all dirty = 0, FSM to IDLE, round-robin pointer = 0.
  - Reset mid-transfer abandons the transfer; dirty data is lost.
- Per-drive state: cur_track, dirty, ready, old_change.
- dirty[d] sets when ready[d] and ram_we[d].
- Rising edge of change[d]:
  - ready[d] <= mount[d]; cur_track[d] <= all-ones; dirty[d] <= 0; busy[d] <= 0.
  - If drive d owns the FSM: clear sd_rd/sd_wr and return to IDLE on the next cycle. This takes priority over a concurrent ack edge.
- Request condition for drive d: ready[d] and any of:
  - cur_track != track[d]
  - falling edge of change[d]
  - dirty[d] and ~active[d]
- FSM states: IDLE, WRITE, READ.
  - IDLE: pick the first requesting drive at or after the pointer (wrapping). Latch it as sel and advance the pointer to sel+1.
    - If dirty[sel] and cur_track[sel] != all-ones: go to WRITE with base = cur_track[sel].
    - Otherwise go to READ with base = track[sel], cur_track[sel] <= track[sel], dirty[sel] <= 0.
    - In both cases: rel = 0, busy[sel] = 1, sd_lba = base*SECTORS, assert the sd_rd/sd_wr bit for sel.
  - sd_ack high clears sd_rd/sd_wr.
  - Sector end = falling edge of sd_ack.
    - If rel != SECTORS-1: rel+1, sd_lba+1, reassert the same request.
  - Last WRITE sector:
    - If track[sel] != cur_track[sel]: switch to READ of track[sel] at rel = 0.
    - Otherwise clear dirty[sel] and busy[sel], return to IDLE.
  - Last READ sector: clear busy[sel], return to IDLE.
- sd_lba arithmetic: 32-bit, zero-extended track*SECTORS + rel. No wrap within the legal track range.
- Buffer write from IO side: only when sd_buff_wr & sd_ack & READ, to track_ram[sel] at rel*512 + sd_buff_addr.
- sd_buff_din: reads the same address of track_ram[sel], registered.
- Disk-side port of each buffer is independent of the FSM. Writes during busy still land and set dirty only if ready.
- Simultaneous IDLE requests: round-robin only; no starvation.
- A drive with ready = 0 never requests.

Optional Feature:
- Macro WRITE_PROTECT_EN.
- Defined: adds input wp [DRIVES], sampled on the change rising edge into wp_l[d].
  - When wp_l[d] = 1: ram_we[d] is ignored for both the RAM write and dirty, and WRITE is never entered for d.
- Undefined: no wp port; all mounted drives are writable.

Test Plan:
- Reset_n low during READ sector 5 of drive 0 -> sd_rd = 0, busy = 0, ready = 0 immediately. No further sd_lba change after release.
- Mount drive 0 (change pulse, mount = 1), track = 3 -> READ with sd_lba 39..51, 13 sd_rd pulses, data lands at offsets 0..1A00h-1, busy[0] falls after the 13th ack.
- Drive 0 on track 3, write byte 55h at 0x100, track -> 4 -> WRITE of lba 39..51 with byte 0x100 = 55h, then READ lba 52..64, dirty cleared.
- Drives 0 and 1 request in the same cycle, pointer = 0 -> drive 0 served first, then drive 1. The next simultaneous request serves drive 1 first.
- Dirty drive 1, active[1] 1 -> 0, track unchanged -> write-back of its current track only, no READ afterwards.
- With WRITE_PROTECT_EN, wp[0] = 1 at mount, ram_we pulses, track change -> no sd_wr, READ only, buffer contents unchanged before reload.

Source files
------------

// File: rtl/mist_sd_track_cache.sv
// mist_sd_track_cache: multi-drive Apple ][ track cache on one shared MiST SD block interface.
// Each drive owns a full-track dual-port buffer. The disk controller side of each buffer
// is always available. The SD side moves whole tracks, one drive at a time, and the
// drives take turns (round-robin). A dirty track is written back before a track change,
// on unmount, or once the drive motor stops.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   sd_lba/sd_rd/sd_wr       sector request to the IO controller (one request bit per drive)
//   sd_ack                   IO controller busy with the current sector; its falling edge ends the sector
//   sd_buff_addr/dout/wr/din byte stream of the current sector (din has 1-cycle latency)
//   change/mount             per-drive image change strobe; mount is sampled on the rising edge
//   track/active             requested track and motor state per drive
//   ready/busy               image usable / track buffer being transferred
//   ram_addr/di/we/do        per-drive disk-side byte port (do has 1-cycle latency)
//
// Optional build macro WRITE_PROTECT_EN adds input wp[DRIVES]. It is sampled on the
// change rising edge, and while it is set it blocks buffer writes and write-back.
module mist_sd_track_cache #(
    parameter  int unsigned DRIVES  = 2,
    parameter  int unsigned SECTORS = 13,
    parameter  int unsigned TRACK_W = 6,
    localparam int unsigned A       = $clog2(SECTORS * 512)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    output logic [31:0]               sd_lba,
    output logic [DRIVES-1:0]         sd_rd,
    output logic [DRIVES-1:0]         sd_wr,
    input  logic                      sd_ack,
    input  logic [8:0]                sd_buff_addr,
    input  logic [7:0]                sd_buff_dout,
    output logic [7:0]                sd_buff_din,
    input  logic                      sd_buff_wr,
    input  logic [DRIVES-1:0]         change,
    input  logic [DRIVES-1:0]         mount,
    input  logic [DRIVES*TRACK_W-1:0] track,
    input  logic [DRIVES-1:0]         active,
    output logic [DRIVES-1:0]         ready,
    output logic [DRIVES-1:0]         busy,
    input  logic [DRIVES*A-1:0]       ram_addr,
    input  logic [DRIVES*8-1:0]       ram_di,
    input  logic [DRIVES-1:0]         ram_we,
`ifdef WRITE_PROTECT_EN
    input  logic [DRIVES-1:0]         wp,
`endif
    output logic [DRIVES*8-1:0]       ram_do
);

    localparam int unsigned DEPTH = SECTORS * 512;
    localparam int unsigned RW    = (SECTORS > 1) ? $clog2(SECTORS) : 1;
    localparam int unsigned DW    = (DRIVES > 1) ? $clog2(DRIVES) : 1;
    localparam logic [TRACK_W-1:0] NO_TRACK = '1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

    state_t             state, state_nxt;
    logic [DW-1:0]      sel, sel_nxt;
    logic [DW-1:0]      ptr, ptr_nxt;
    logic [RW-1:0]      rel, rel_nxt;
    logic [31:0]        lba_nxt;
    logic [DRIVES-1:0]  rd_nxt, wr_nxt, busy_nxt, ready_nxt, dirty, dirty_nxt;
    logic [DRIVES-1:0]  old_change;
    logic               ack_q;
    logic [TRACK_W-1:0] cur_track [DRIVES];
    logic [TRACK_W-1:0] cur_nxt   [DRIVES];
    logic [TRACK_W-1:0] trk       [DRIVES];

    logic [DRIVES-1:0]  change_rise, change_fall, wp_mask, we_eff, wr_ok, req;
    logic [DW-1:0]      pick, cand;
    logic               ack_fall, last, abort;

    function automatic logic [31:0] lba_of(input logic [TRACK_W-1:0] t);
        return 32'(t) * 32'(SECTORS);
    endfunction

`ifdef WRITE_PROTECT_EN
    logic [DRIVES-1:0] wp_l;

    // Write-protect state is captured together with the image change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_l <= '0;
        end else begin
            for (int d = 0; d < DRIVES; d++) begin
                if (change_rise[d]) wp_l[d] <= wp[d];
            end
        end
    end
    assign wp_mask = wp_l;
`else
    assign wp_mask = '0;
`endif

    // Per-drive status and request decode
    always_comb begin
        for (int d = 0; d < DRIVES; d++) trk[d] = track[d*TRACK_W +: TRACK_W];
        change_rise = change & ~old_change;
        change_fall = ~change & old_change;
        we_eff      = ram_we & ~wp_mask;
        for (int d = 0; d < DRIVES; d++) begin
            wr_ok[d] = dirty[d] & (cur_track[d] != NO_TRACK) & ~wp_mask[d];
            req[d]   = ready[d] & ((cur_track[d] != trk[d]) | change_fall[d] |
                                   (dirty[d] & ~active[d]));
        end
    end

    // Round-robin pick: first requester at or after ptr. Scanning backwards makes the lowest offset win
    always_comb begin
        pick = ptr;
        cand = ptr;
        for (int i = DRIVES - 1; i >= 0; i--) begin
            cand = DW'((32'(ptr) + 32'(i)) % DRIVES);
            if (req[cand]) pick = cand;
        end
    end

    assign ack_fall = ack_q & ~sd_ack;
    assign last     = (rel == RW'(SECTORS - 1));
    // An image change on the owning drive cancels its transfer
    assign abort    = change_rise[sel];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (|req) state_nxt = wr_ok[pick] ? S_WRITE : S_READ;
            end
            S_WRITE: begin
                if (abort)                 state_nxt = S_IDLE;
                else if (ack_fall && last) state_nxt = (trk[sel] != cur_track[sel]) ? S_READ : S_IDLE;
            end
            S_READ: begin
                if (abort)                 state_nxt = S_IDLE;
                else if (ack_fall && last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        sel_nxt   = sel;
        ptr_nxt   = ptr;
        rel_nxt   = rel;
        lba_nxt   = sd_lba;
        rd_nxt    = sd_rd;
        wr_nxt    = sd_wr;
        busy_nxt  = busy;
        ready_nxt = ready;
        dirty_nxt = dirty;
        cur_nxt   = cur_track;

        if (sd_ack) begin
            rd_nxt = '0;
            wr_nxt = '0;
        end

        unique case (state)
            S_IDLE: begin
                if (|req) begin
                    sel_nxt        = pick;
                    ptr_nxt        = (pick == DW'(DRIVES - 1)) ? '0 : pick + DW'(1);
                    rel_nxt        = '0;
                    busy_nxt[pick] = 1'b1;
                    if (wr_ok[pick]) begin
                        lba_nxt      = lba_of(cur_track[pick]);
                        wr_nxt[pick] = 1'b1;
                    end else begin
                        lba_nxt         = lba_of(trk[pick]);
                        rd_nxt[pick]    = 1'b1;
                        cur_nxt[pick]   = trk[pick];
                        dirty_nxt[pick] = 1'b0;
                    end
                end
            end
            S_WRITE, S_READ: begin
                if (abort) begin
                    rd_nxt = '0;
                    wr_nxt = '0;
                end else if (ack_fall) begin
                    if (!last) begin
                        rel_nxt = rel + RW'(1);
                        lba_nxt = sd_lba + 32'd1;
                        if (state == S_WRITE) wr_nxt[sel] = 1'b1;
                        else                  rd_nxt[sel] = 1'b1;
                    end else if (state == S_WRITE && trk[sel] != cur_track[sel]) begin
                        // Write-back done, now fetch the requested track
                        rel_nxt        = '0;
                        lba_nxt        = lba_of(trk[sel]);
                        rd_nxt[sel]    = 1'b1;
                        cur_nxt[sel]   = trk[sel];
                        dirty_nxt[sel] = 1'b0;
                    end else begin
                        if (state == S_WRITE) dirty_nxt[sel] = 1'b0;
                        busy_nxt[sel] = 1'b0;
                    end
                end
            end
            default: ;
        endcase

        // Disk-side writes mark the buffer dirty even while it is being transferred
        for (int d = 0; d < DRIVES; d++) begin
            if (ready[d] && we_eff[d]) dirty_nxt[d] = 1'b1;
        end

        // An image change resets the drive state and overrides everything else
        for (int d = 0; d < DRIVES; d++) begin
            if (change_rise[d]) begin
                ready_nxt[d] = mount[d];
                cur_nxt[d]   = NO_TRACK;
                dirty_nxt[d] = 1'b0;
                busy_nxt[d]  = 1'b0;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel        <= '0;
            ptr        <= '0;
            rel        <= '0;
            sd_lba     <= '0;
            sd_rd      <= '0;
            sd_wr      <= '0;
            busy       <= '0;
            ready      <= '0;
            dirty      <= '0;
            old_change <= '0;
            ack_q      <= 1'b0;
            for (int d = 0; d < DRIVES; d++) cur_track[d] <= NO_TRACK;
        end else begin
            sel        <= sel_nxt;
            ptr        <= ptr_nxt;
            rel        <= rel_nxt;
            sd_lba     <= lba_nxt;
            sd_rd      <= rd_nxt;
            sd_wr      <= wr_nxt;
            busy       <= busy_nxt;
            ready      <= ready_nxt;
            dirty      <= dirty_nxt;
            old_change <= change;
            ack_q      <= sd_ack;
            cur_track  <= cur_nxt;
        end
    end

    // Track buffers: disk port per drive, SD port on the selected drive
    logic [7:0]   mem [DRIVES][DEPTH];
    logic [A-1:0] io_addr;
    logic         io_we;

    assign io_addr = A'(32'(rel) * 32'd512 + 32'(sd_buff_addr));
    assign io_we   = sd_buff_wr & sd_ack & (state == S_READ);

    always_ff @(posedge clk) begin
        for (int d = 0; d < DRIVES; d++) begin
            if (we_eff[d]) mem[d][ram_addr[d*A +: A]] <= ram_di[d*8 +: 8];
            ram_do[d*8 +: 8] <= mem[d][ram_addr[d*A +: A]];
        end
        if (io_we) mem[sel][io_addr] <= sd_buff_dout;
        sd_buff_din <= mem[sel][io_addr];
    end

endmodule

// File: tb/tb_mist_sd_track_cache.sv
// Directed bench for mist_sd_track_cache (DRIVES=2, SECTORS=13, TRACK_W=6).
// A small IO-controller model acknowledges each sector, feeds a few bytes per read
// sector and samples sd_buff_din on write sectors.
module tb_mist_sd_track_cache;

    localparam int unsigned DRIVES  = 2;
    localparam int unsigned SECTORS = 13;
    localparam int unsigned TRACK_W = 6;
    localparam int unsigned A       = 13;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [31:0]               sd_lba;
    logic [DRIVES-1:0]         sd_rd, sd_wr;
    logic                      sd_ack;
    logic [8:0]                sd_buff_addr;
    logic [7:0]                sd_buff_dout, sd_buff_din;
    logic                      sd_buff_wr;
    logic [DRIVES-1:0]         change, mount, active, ready, busy, ram_we;
    logic [DRIVES*TRACK_W-1:0] track;
    logic [DRIVES*A-1:0]       ram_addr;
    logic [DRIVES*8-1:0]       ram_di, ram_do;
`ifdef WRITE_PROTECT_EN
    logic [DRIVES-1:0]         wp = '0;
`endif

    int tests = 0;
    int fails = 0;

    mist_sd_track_cache #(.DRIVES(DRIVES), .SECTORS(SECTORS), .TRACK_W(TRACK_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr),
        .change(change), .mount(mount), .track(track), .active(active),
        .ready(ready), .busy(busy),
        .ram_addr(ram_addr), .ram_di(ram_di), .ram_we(ram_we),
`ifdef WRITE_PROTECT_EN
        .wp(wp),
`endif
        .ram_do(ram_do)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sector contents the IO model supplies for a given LBA and byte offset
    function automatic logic [7:0] pat(input logic [31:0] lba, input int unsigned a);
        return 8'(lba * 32'd5 + 32'(a) * 32'd3);
    endfunction

    task automatic serve_sector(input bit is_wr, input int d, input logic [31:0] lba,
                                input bit chk_x, input logic [8:0] x_addr, input logic [7:0] x_val);
        int n;
        logic [DRIVES-1:0] bitd;
        n    = 0;
        bitd = DRIVES'(1) << d;
        while ((sd_rd | sd_wr) == '0 && n < 200) begin
            tick();
            n++;
        end
        check("sd_rd", 32'(sd_rd), is_wr ? 32'd0 : 32'(bitd));
        check("sd_wr", 32'(sd_wr), is_wr ? 32'(bitd) : 32'd0);
        check("sd_lba", sd_lba, lba);
        check("busy_during", 32'(busy[d]), 32'd1);
        sd_ack = 1'b1;
        tick();
        check("req_clear_on_ack", 32'(sd_rd | sd_wr), 32'd0);
        if (!is_wr) begin
            for (int k = 0; k < 3; k++) begin
                sd_buff_addr = (k == 2) ? 9'd511 : 9'(k);
                sd_buff_dout = pat(lba, (k == 2) ? 511 : k);
                sd_buff_wr   = 1'b1;
                tick();
                sd_buff_wr   = 1'b0;
            end
        end else begin
            sd_buff_addr = 9'd1;
            tick();
            check("wr_din", 32'(sd_buff_din), 32'(pat(lba, 1)));
            if (chk_x) begin
                sd_buff_addr = x_addr;
                tick();
                check("wr_din_x", 32'(sd_buff_din), 32'(x_val));
            end
        end
        sd_ack = 1'b0;
        tick();
    endtask

    task automatic serve_track(input bit is_wr, input int d, input logic [31:0] base, input int nsec,
                               input bit idle_end, input logic [8:0] x_addr, input logic [7:0] x_val,
                               input bit x_en);
        for (int s = 0; s < nsec; s++) begin
            serve_sector(is_wr, d, base + 32'(s), x_en && (s == 0), x_addr, x_val);
        end
        if (idle_end) check("busy_end", 32'(busy[d]), 32'd0);
    endtask

    task automatic mount_drive(input int d);
        change[d] = 1'b1;
        mount[d]  = 1'b1;
        tick();
        change[d] = 1'b0;
    endtask

    task automatic disk_write(input int d, input logic [A-1:0] a, input logic [7:0] v);
        ram_addr[d*A +: A] = a;
        ram_di[d*8 +: 8]   = v;
        ram_we[d]          = 1'b1;
        tick();
        ram_we[d]          = 1'b0;
    endtask

    task automatic check_ram(input string tag, input int d, input logic [A-1:0] a, input logic [7:0] exp);
        ram_addr[d*A +: A] = a;
        tick();
        check(tag, 32'(ram_do[d*8 +: 8]), 32'(exp));
    endtask

    initial begin
        int n;
        reset_n      = 1'b0;
        sd_ack       = 1'b0;
        sd_buff_addr = '0;
        sd_buff_dout = '0;
        sd_buff_wr   = 1'b0;
        change       = '0;
        mount        = '0;
        active       = '1;
        track        = '0;
        ram_addr     = '0;
        ram_di       = '0;
        ram_we       = '0;
        repeat (3) tick();

        // Reset state
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sd_rd", 32'(sd_rd), 32'd0);
        check("rst_sd_wr", 32'(sd_wr), 32'd0);
        check("rst_sd_lba", sd_lba, 32'd0);
        reset_n = 1'b1;
        tick();

        // Mount drive 0 on track 3: read LBA 39..51
        track[0*TRACK_W +: TRACK_W] = 6'd3;
        mount_drive(0);
        check("mount_ready", 32'(ready), 32'b01);
        serve_track(1'b0, 0, 32'd39, 13, 1'b1, 9'd0, 8'd0, 1'b0);
        check_ram("ram_0000", 0, 13'h0000, pat(39, 0));
        check_ram("ram_01ff", 0, 13'h01FF, pat(39, 511));
        check_ram("ram_0c01", 0, 13'h0C01, pat(45, 1));
        check_ram("ram_19ff", 0, 13'h19FF, pat(51, 511));

        // Dirty track 3 with motor on: no write-back yet
        disk_write(0, 13'h0100, 8'h55);
        repeat (5) tick();
        check("deferred_wb", 32'(sd_rd | sd_wr), 32'd0);
        check_ram("ram_0100", 0, 13'h0100, 8'h55);

        // Track change: write back LBA 39..51, then read LBA 52..64
        track[0*TRACK_W +: TRACK_W] = 6'd4;
        serve_track(1'b1, 0, 32'd39, 13, 1'b0, 9'h100, 8'h55, 1'b1);
        serve_track(1'b0, 0, 32'd52, 13, 1'b1, 9'd0, 8'd0, 1'b0);
        active[0] = 1'b0;
        repeat (20) tick();
        check("clean_after_wb", 32'(sd_rd | sd_wr), 32'd0);

        // Mount drive 1 on track 2 (pointer wraps back to drive 0)
        track[1*TRACK_W +: TRACK_W] = 6'd2;
        mount_drive(1);
        serve_track(1'b0, 1, 32'd26, 13, 1'b1, 9'd0, 8'd0, 1'b0);

        // Simultaneous requests with pointer at drive 0
        track[0*TRACK_W +: TRACK_W] = 6'd5;
        track[1*TRACK_W +: TRACK_W] = 6'd9;
        serve_track(1'b0, 0, 32'd65, 13, 1'b1, 9'd0, 8'd0, 1'b0);
        serve_track(1'b0, 1, 32'd117, 13, 1'b1, 9'd0, 8'd0, 1'b0);

        // Drive 0 alone moves the pointer to drive 1, then both request again
        track[0*TRACK_W +: TRACK_W] = 6'd6;
        serve_track(1'b0, 0, 32'd78, 13, 1'b1, 9'd0, 8'd0, 1'b0);
        track[0*TRACK_W +: TRACK_W] = 6'd7;
        track[1*TRACK_W +: TRACK_W] = 6'd10;
        serve_track(1'b0, 1, 32'd130, 13, 1'b1, 9'd0, 8'd0, 1'b0);
        serve_track(1'b0, 0, 32'd91, 13, 1'b1, 9'd0, 8'd0, 1'b0);

        // Drive 1 dirty, motor stops: write-back of track 10 only
        disk_write(1, 13'h0005, 8'hA5);
        repeat (5) tick();
        check("d1_deferred", 32'(sd_rd | sd_wr), 32'd0);
        active[1] = 1'b0;
        serve_track(1'b1, 1, 32'd130, 13, 1'b1, 9'd5, 8'hA5, 1'b1);
        repeat (30) tick();
        check("no_read_after_idle_wb", 32'(sd_rd | sd_wr), 32'd0);
        check("busy_after_idle_wb", 32'(busy), 32'd0);

        // Reset in the middle of sector 5 of a read
        track[0*TRACK_W +: TRACK_W] = 6'd8;
        serve_track(1'b0, 0, 32'd104, 5, 1'b0, 9'd0, 8'd0, 1'b0);
        n = 0;
        while (sd_rd == '0 && n < 200) begin
            tick();
            n++;
        end
        check("sec5_lba", sd_lba, 32'd109);
        check("sec5_rd", 32'(sd_rd), 32'b01);
        sd_ack = 1'b1;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_sd_rd", 32'(sd_rd), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(ready), 32'd0);
        check("midrst_lba", sd_lba, 32'd0);
        sd_ack = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (20) tick();
        check("post_rst_lba", sd_lba, 32'd0);
        check("post_rst_req", 32'(sd_rd | sd_wr), 32'd0);
        check("post_rst_ready", 32'(ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
